mips_multicycle_core: RTL and testbench

//  Multi-cycle MIPS-subset core: one FSM sequences fetch/decode/execute/memory/writeback over a single

---
 rtl/mips_multicycle_core.sv | 116 +++++++++++
 tb/tb_mips_multicycle_core.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS-subset CPU sequenced over one unified req/ready memory port
module mips_multicycle_core #(
  parameter int          ADDR_W          = 12,
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [31:0]       pc_out,
  output logic              halted,
  output logic              illegal
);
  localparam logic [31:0] AMASK = (32'd1 << ADDR_W) - 32'd4;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state;
  logic [31:0] pc, ir, a, b, imm, res, alu, tgt;
  logic [31:0] rf [32];
  logic [5:0] op, fn;
  logic [4:0] dst;
  logic is_r, is_lw, is_sw, legal, to_fetch;
  assign op = ir[31:26];
  assign fn = ir[5:0];
  always_comb begin
    is_r = op == 6'h00;
    is_lw = op == 6'h23;
    is_sw = op == 6'h2b;
    legal = is_r ? fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2a}
                 : op inside {6'h0d, 6'h09, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02};
    dst = is_r ? ir[15:11] : ir[20:16];
    alu = is_r ? (fn == 6'h21 ? a + b :
                  fn == 6'h23 ? a - b :
                  fn == 6'h24 ? a & b :
                  fn == 6'h25 ? a | b : {31'b0, $signed(a) < $signed(b)})
               : op == 6'h0d ? a | imm : op == 6'h0f ? imm : a + imm;
    // pc already holds the incremented PC here, so branch offsets are relative to PC+4
    tgt = op == 6'h02 ? ({pc[31:28], ir[25:0], 2'b00} & AMASK)
        : (op == 6'h04 && a == b) ? ((pc + (imm << 2)) & AMASK) : pc;
    to_fetch = (state == EXEC && (!legal || op == 6'h02 || op == 6'h04))
            || (state == MEM && is_sw && mem_req && mem_ready) || state == WB;
  end
  assign retire = to_fetch;
  assign halted = state == HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC & AMASK;
      pc_out <= RESET_PC & AMASK;
      ir <= '0;
      a <= '0;
      b <= '0;
      imm <= '0;
      res <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH:
          if (mem_req && mem_ready) begin
            ir <= mem_rdata;
            pc <= (pc + 32'd4) & AMASK;
            mem_req <= 1'b0;
            state <= DECODE;
          end else if (!mem_req) begin
            mem_req <= 1'b1;
            mem_addr <= pc[ADDR_W-1:0];
          end
        DECODE: begin
          a <= rf[ir[25:21]];
          b <= rf[ir[20:16]];
          imm <= op == 6'h0d ? {16'h0, ir[15:0]} : op == 6'h0f ? {ir[15:0], 16'h0} : {{16{ir[15]}}, ir[15:0]};
          illegal <= illegal | !legal;
          state <= (!legal && HALT_ON_ILLEGAL) ? HALT : EXEC;
        end
        EXEC: begin
          res <= alu;
          state <= (is_lw || is_sw) ? MEM : WB;
          if (is_lw || is_sw) begin
            mem_req <= 1'b1;
            mem_we <= is_sw;
            mem_addr <= {alu[ADDR_W-1:2], 2'b00};
            mem_wdata <= b;
          end
        end
        MEM:
          if (mem_ready) begin
            res <= mem_rdata;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            state <= WB;
          end
        WB: if (dst != 5'd0) rf[dst] <= res;
        default: ;
      endcase
      // the last cycle of every instruction issues the next fetch directly
      if (to_fetch) begin
        state <= FETCH;
        pc <= tgt;
        pc_out <= tgt;
        mem_req <= 1'b1;
        mem_we <= 1'b0;
        mem_addr <= tgt[ADDR_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: scoreboarded bench with a wait-state memory model and a second non-halting core
module tb_mips_multicycle_core;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic mem_req, mem_we, mem_ready = 0, retire, halted, illegal;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = 0, pc_out;
  logic n_req, n_we, n_ready = 0, n_retire, n_halted, n_illegal;
  logic [11:0] n_addr;
  logic [31:0] n_wdata, n_rdata = 0, n_pc_out;

  mips_multicycle_core #(.ADDR_W(12), .RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .retire(retire),
    .pc_out(pc_out), .halted(halted), .illegal(illegal));

  mips_multicycle_core #(.ADDR_W(12), .RESET_PC(32'h43), .HALT_ON_ILLEGAL(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .mem_req(n_req), .mem_we(n_we), .mem_addr(n_addr),
    .mem_wdata(n_wdata), .mem_rdata(n_rdata), .mem_ready(n_ready), .retire(n_retire),
    .pc_out(n_pc_out), .halted(n_halted), .illegal(n_illegal));

  logic [31:0] mem [1024];
  int n_checks = 0, n_errors = 0, cyc = 0, wait_n = 0, first_req = -1, cnt = 0;
  logic [11:0] first_addr;
  int ret_cyc[$], n_ret_cyc[$];
  logic [31:0] ret_pc[$], n_ret_pc[$];
  logic [11:0] wq_a[$];
  logic [31:0] wq_d[$];
  bit busy = 0;
  logic [44:0] cap;
  logic [11:0] ea;
  logic [31:0] ed;

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] rr(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] jj(input logic [25:0] t);
    return {6'h02, t};
  endfunction
  function automatic logic [31:0] rom2(input logic [11:0] a);
    return a == 12'h040 ? 32'hFC00_0000 : a == 12'h044 ? 32'h0000_003F : a == 12'h048 ? {6'h02, 26'h12} : 32'h0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // main memory: wait_n wait cycles per transfer, checks stores against the scoreboard
  always @(posedge clk) begin
    #1;
    if (rst || !mem_req) begin
      mem_ready = 0;
      busy = 0;
    end else begin
      if (!busy || mem_ready) begin
        busy = 1;
        cnt = 0;
        cap = {mem_addr, mem_we, mem_wdata};
      end else begin
        n_checks++;
        if ({mem_addr, mem_we, mem_wdata} !== cap) begin
          n_errors++;
          $display("FAIL hold_stable: got %h, want %h", {mem_addr, mem_we, mem_wdata}, cap);
        end
      end
      if (cnt == wait_n) begin
        mem_ready = 1;
        if (mem_we) begin
          n_checks++;
          if (wq_a.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_store: addr %h data %h, want no store", mem_addr, mem_wdata);
          end else begin
            ea = wq_a.pop_front();
            ed = wq_d.pop_front();
            if (mem_addr !== ea || mem_wdata !== ed) begin
              n_errors++;
              $display("FAIL store: got %h<=%h, want %h<=%h", mem_addr, mem_wdata, ea, ed);
            end
          end
          mem[mem_addr[11:2]] = mem_wdata;
        end else mem_rdata = mem[mem_addr[11:2]];
      end else begin
        mem_ready = 0;
        cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    n_ready = n_req && !rst;
    n_rdata = rom2(n_addr);
  end

  always @(negedge clk) if (!rst) begin
    if (retire) begin ret_cyc.push_back(cyc); ret_pc.push_back(pc_out); end
    if (n_retire) begin n_ret_cyc.push_back(cyc); n_ret_pc.push_back(n_pc_out); end
    if (mem_req && first_req < 0) begin first_req = cyc; first_addr = mem_addr; end
  end

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    ret_cyc.delete(); ret_pc.delete(); n_ret_cyc.delete(); n_ret_pc.delete();
    wq_a.delete(); wq_d.delete();
    first_req = -1;
    rst = 0;
  endtask

  task automatic push_store(input logic [11:0] a, input logic [31:0] d);
    wq_a.push_back(a);
    wq_d.push_back(d);
  endtask

  task automatic wait_ret(input int k, input string nm);
    int t = 0;
    while (ret_pc.size() < k && t < 600) begin @(negedge clk); t++; end
    n_checks++;
    if (ret_pc.size() < k) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d retires, want %0d", nm, ret_pc.size(), k);
    end
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = jj(26'd0);
    wait_n = 0;
    do_reset();
    n_checks++;
    if ({mem_req, mem_we, retire, halted, illegal} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b, want 00000", {mem_req, mem_we, retire, halted, illegal});
    end
    n_checks++;
    if (mem_addr !== 12'h0 || mem_wdata !== 32'h0 || pc_out !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_regs: got addr %h wdata %h pc %h, want 0 0 0", mem_addr, mem_wdata, pc_out);
    end
    n_checks++;
    if (n_pc_out !== 32'h40) begin
      n_errors++;
      $display("FAIL reset_pc_align: got %h, want 00000040", n_pc_out);
    end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h0) begin
      n_errors++;
      $display("FAIL first_fetch: got req %b we %b addr %h, want 1 0 000", mem_req, mem_we, mem_addr);
    end
  endtask

  task automatic test_alu_basic();
    clear_mem();
    mem[0] = ri(6'h0d, 0, 1, 16'h1234);
    mem[1] = rr(2, 1, 1, 6'h21);
    mem[2] = ri(6'h2b, 0, 2, 16'h0100);
    mem[3] = jj(26'd3);
    wait_n = 0;
    do_reset();
    push_store(12'h100, 32'h2468);
    wait_ret(3, "basic");
    n_checks++;
    if (ret_cyc[0] - first_req != 3 || ret_cyc[1] - first_req != 7) begin
      n_errors++;
      $display("FAIL basic_retire_cycles: got %0d,%0d, want 3,7", ret_cyc[0] - first_req, ret_cyc[1] - first_req);
    end
    n_checks++;
    if (ret_cyc[2] - ret_cyc[1] != 4 || ret_pc[1] !== 32'h4) begin
      n_errors++;
      $display("FAIL basic_sw: got lat %0d pc %h, want 4 00000004", ret_cyc[2] - ret_cyc[1], ret_pc[1]);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wq_a.size() != 0) begin n_errors++; $display("FAIL basic_pending: got %0d, want 0", wq_a.size()); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp_v [9] = '{32'h80000000, 32'h1, 32'h1, 32'h80000001, 32'h80000000,
                               32'h80000001, 32'hFFFFFFFF, 32'h0, 32'h0000FFFF};
    clear_mem();
    mem[0] = ri(6'h0f, 0, 4, 16'h8000);
    mem[1] = ri(6'h0d, 0, 5, 16'h0001);
    mem[2] = rr(6, 4, 5, 6'h2a);
    mem[3] = rr(7, 5, 4, 6'h23);
    mem[4] = rr(8, 4, 7, 6'h24);
    mem[5] = rr(9, 5, 4, 6'h25);
    mem[6] = ri(6'h09, 5, 10, 16'hFFFE);
    mem[7] = rr(11, 5, 4, 6'h2a);
    mem[8] = ri(6'h0d, 0, 12, 16'hFFFF);
    for (int r = 0; r < 9; r++) mem[9 + r] = ri(6'h2b, 0, 5'(r + 4), 16'(12'h200 + 4 * r));
    mem[18] = jj(26'd18);
    wait_n = 0;
    do_reset();
    for (int r = 0; r < 9; r++) push_store(12'(12'h200 + 4 * r), exp_v[r]);
    wait_ret(19, "alu");
    repeat (3) @(negedge clk);
    n_checks++;
    if (wq_a.size() != 0) begin n_errors++; $display("FAIL alu_pending: got %0d, want 0", wq_a.size()); end
    n_checks++;
    if (ret_cyc[3] - ret_cyc[2] != 4 || ret_pc[18] !== 32'h48) begin
      n_errors++;
      $display("FAIL alu_timing: got lat %0d pc %h, want 4 00000048", ret_cyc[3] - ret_cyc[2], ret_pc[18]);
    end
  endtask

  task automatic test_mem_wait();
    clear_mem();
    mem[0] = ri(6'h0d, 0, 2, 16'h2468);
    mem[1] = ri(6'h2b, 0, 2, 16'h0108);
    mem[2] = ri(6'h23, 0, 3, 16'h0108);
    mem[3] = ri(6'h2b, 0, 3, 16'h0110);
    mem[4] = jj(26'd4);
    wait_n = 3;
    do_reset();
    push_store(12'h108, 32'h2468);
    push_store(12'h110, 32'h2468);
    wait_ret(4, "wait");
    n_checks++;
    if (ret_cyc[0] - first_req != 6 || ret_cyc[1] - ret_cyc[0] != 10 || ret_cyc[2] - ret_cyc[1] != 11) begin
      n_errors++;
      $display("FAIL wait_latency: got %0d,%0d,%0d, want 6,10,11",
               ret_cyc[0] - first_req, ret_cyc[1] - ret_cyc[0], ret_cyc[2] - ret_cyc[1]);
    end
    n_checks++;
    if (mem[12'h108 >> 2] !== 32'h2468 || wq_a.size() != 0) begin
      n_errors++;
      $display("FAIL wait_data: got mem %h pending %0d, want 00002468 0", mem[12'h108 >> 2], wq_a.size());
    end
    wait_n = 0;
  endtask

  task automatic test_branch();
    clear_mem();
    mem[0] = ri(6'h0d, 0, 1, 16'h0001);
    mem[1] = jj(26'h4);
    mem[4] = ri(6'h04, 1, 1, 16'hFFFF);
    do_reset();
    wait_ret(4, "beq_taken");
    n_checks++;
    if (ret_pc[2] !== 32'h10 || ret_pc[3] !== 32'h10 || ret_cyc[3] - ret_cyc[2] != 3 || ret_cyc[2] - ret_cyc[1] != 3) begin
      n_errors++;
      $display("FAIL beq_taken: got pc %h,%h lat %0d,%0d, want 10,10 3,3", ret_pc[2], ret_pc[3],
               ret_cyc[2] - ret_cyc[1], ret_cyc[3] - ret_cyc[2]);
    end
    mem[4] = ri(6'h04, 1, 0, 16'hFFFF);
    mem[5] = jj(26'h5);
    do_reset();
    wait_ret(4, "beq_not_taken");
    n_checks++;
    if (ret_pc[3] !== 32'h14 || ret_cyc[3] - ret_cyc[2] != 3) begin
      n_errors++;
      $display("FAIL beq_not_taken: got pc %h lat %0d, want 00000014 3", ret_pc[3], ret_cyc[3] - ret_cyc[2]);
    end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[0] = jj(26'h13FF);
    mem[1023] = ri(6'h0d, 0, 1, 16'h0055);
    do_reset();
    wait_ret(3, "wrap");
    n_checks++;
    if (ret_pc[1] !== 32'hFFC || ret_pc[2] !== 32'h0 || ret_cyc[0] - first_req != 2) begin
      n_errors++;
      $display("FAIL pc_wrap: got pc %h,%h j lat %0d, want ffc,0 2", ret_pc[1], ret_pc[2], ret_cyc[0] - first_req);
    end
  endtask

  task automatic test_illegal();
    int nreq = 0;
    clear_mem();
    mem[0] = ri(6'h0d, 0, 1, 16'h0001);
    mem[1] = 32'hFC00_0000;
    mem[2] = ri(6'h2b, 0, 1, 16'h0100);
    do_reset();
    repeat (25) @(negedge clk);
    n_checks++;
    if (illegal !== 1'b1 || halted !== 1'b1 || ret_pc.size() != 1) begin
      n_errors++;
      $display("FAIL illegal_halt: got ill %b halt %b retires %0d, want 1 1 1", illegal, halted, ret_pc.size());
    end
    repeat (10) begin @(negedge clk); nreq += int'(mem_req); end
    n_checks++;
    if (nreq != 0) begin n_errors++; $display("FAIL halt_quiet: got %0d req cycles, want 0", nreq); end
    n_checks++;
    if (n_illegal !== 1'b1 || n_halted !== 1'b0) begin
      n_errors++;
      $display("FAIL nop_flags: got ill %b halt %b, want 1 0", n_illegal, n_halted);
    end
    n_checks++;
    if (n_ret_pc[0] !== 32'h40 || n_ret_pc[1] !== 32'h44 || n_ret_pc[2] !== 32'h48 || n_ret_cyc[1] - n_ret_cyc[0] != 3) begin
      n_errors++;
      $display("FAIL nop_retire: got pc %h,%h,%h lat %0d, want 40,44,48 3", n_ret_pc[0], n_ret_pc[1], n_ret_pc[2],
               n_ret_cyc[1] - n_ret_cyc[0]);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int t = 0;
    clear_mem();
    mem[0] = ri(6'h09, 0, 0, 16'd5);
    mem[1] = ri(6'h2b, 0, 0, 16'h0100);
    mem[2] = jj(26'd2);
    wait_n = 5;
    do_reset();
    while (first_req < 0 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL pre_abort: got req %b ready %b, want 1 0", mem_req, mem_ready);
    end
    rst = 1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin n_errors++; $display("FAIL abort_req: got %b, want 0", mem_req); end
    ret_cyc.delete(); ret_pc.delete();
    first_req = -1;
    wait_n = 0;
    push_store(12'h100, 32'h0);
    rst = 0;
    t = 0;
    while (first_req < 0 && t < 50) begin @(negedge clk); t++; end
    n_checks++;
    if (first_req < 0 || first_addr !== 12'h0) begin
      n_errors++;
      $display("FAIL refetch_addr: got %h (seen %0d), want 000", first_addr, first_req >= 0);
    end
    wait_ret(3, "zero_reg");
    repeat (3) @(negedge clk);
    n_checks++;
    if (wq_a.size() != 0 || ret_pc[0] !== 32'h0) begin
      n_errors++;
      $display("FAIL zero_reg: got pending %0d pc %h, want 0 00000000", wq_a.size(), ret_pc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_alu_ops();
    test_mem_wait();
    test_branch();
    test_pc_wrap();
    test_illegal();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no completion, want finish");
    $fatal(1);
  end
endmodule
